// File: rtl/bomb_scheduler.sv
// Bomb slot manager: grid-snapped placement, per-slot fuse/blast timers, and a
// lowest-index-first arbiter that serialises detonations onto the explosion bus.
module bomb_scheduler #(
  parameter int MAX_BOMBS   = 2,
  parameter int TICK_DIV    = 250000,
  parameter int FUSE_TICKS  = 200,
  parameter int BLAST_TICKS = 50,
  parameter int MIN_X       = 143,
  parameter int MIN_Y       = 34
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C,
  input  logic [9:0]             b_x,
  input  logic [9:0]             b_y,
  input  logic                   game_over,
  output logic                   explosion_SCEN,
  output logic [9:0]             e_x,
  output logic [9:0]             e_y,
  output logic [MAX_BOMBS-1:0]   bomb_valid,
  output logic [10*MAX_BOMBS-1:0] bomb_x,
  output logic [10*MAX_BOMBS-1:0] bomb_y,
  output logic [MAX_BOMBS-1:0]   blast_valid,
  output logic [2:0]             bombs_free
);

  typedef enum logic [1:0] {S_EMPTY, S_ARMED, S_PENDING, S_BLAST} slot_state_t;

  slot_state_t st   [MAX_BOMBS];
  slot_state_t st_n [MAX_BOMBS];
  logic [7:0]  cnt   [MAX_BOMBS];
  logic [7:0]  cnt_n [MAX_BOMBS];
  logic [9:0]  px    [MAX_BOMBS];
  logic [9:0]  py    [MAX_BOMBS];
  logic [9:0]  px_n  [MAX_BOMBS];
  logic [9:0]  py_n  [MAX_BOMBS];

  logic [17:0] presc;
  logic        tick;
  logic        c_d;
  logic        c_rise;
  logic [9:0]  tx, ty;

  logic        grant;
  logic [1:0]  grant_idx;
  logic [9:0]  grant_x, grant_y;
  logic        free_found;
  logic [1:0]  free_idx;
  logic        dup;
  logic        accept;
  logic [2:0]  free_n;

  assign tick   = (presc == 18'(TICK_DIV - 1));
  assign c_rise = C & ~c_d;
  assign tx     = 10'(MIN_X) + ((b_x - 10'(MIN_X) + 10'd8) & 10'h3F0);
  assign ty     = 10'(MIN_Y) + ((b_y - 10'(MIN_Y) + 10'd8) & 10'h3F0);

  // All decisions (grant, free slot, duplicate tile) use the pre-edge slot states,
  // so a slot leaving BLAST this cycle is not yet offered to a drop.
  always_comb begin
    grant      = 1'b0;
    grant_idx  = '0;
    grant_x    = '0;
    grant_y    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    dup        = 1'b0;
    for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
      if (!grant && st[i] == S_PENDING) begin
        grant     = 1'b1;
        grant_idx = 2'(i);
        grant_x   = px[i];
        grant_y   = py[i];
      end
      if (!free_found && st[i] == S_EMPTY) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
      if ((st[i] == S_ARMED || st[i] == S_PENDING) && px[i] == tx && py[i] == ty)
        dup = 1'b1;
    end
    accept = c_rise & ~game_over & free_found & ~dup;

    free_n = '0;
    for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
      st_n[i]  = st[i];
      cnt_n[i] = cnt[i];
      px_n[i]  = px[i];
      py_n[i]  = py[i];
      case (st[i])
        S_EMPTY: begin
          if (accept && free_idx == 2'(i)) begin
            st_n[i]  = S_ARMED;
            cnt_n[i] = 8'(FUSE_TICKS);
            px_n[i]  = tx;
            py_n[i]  = ty;
          end
        end
        S_ARMED: begin
          if (cnt[i] == 8'd0)
            st_n[i] = S_PENDING;
          else if (tick)
            cnt_n[i] = cnt[i] - 8'd1;
        end
        S_PENDING: begin
          if (grant && grant_idx == 2'(i)) begin
            st_n[i]  = S_BLAST;
            cnt_n[i] = 8'(BLAST_TICKS);
          end
        end
        S_BLAST: begin
          if (cnt[i] == 8'd0)
            st_n[i] = S_EMPTY;
          else if (tick)
            cnt_n[i] = cnt[i] - 8'd1;
        end
        default: st_n[i] = S_EMPTY;
      endcase
      if (st_n[i] == S_EMPTY)
        free_n = free_n + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc          <= '0;
      c_d            <= 1'b0;
      explosion_SCEN <= 1'b0;
      e_x            <= '0;
      e_y            <= '0;
      bomb_valid     <= '0;
      blast_valid    <= '0;
      bombs_free     <= 3'(MAX_BOMBS);
      for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
        st[i]  <= S_EMPTY;
        cnt[i] <= '0;
        px[i]  <= '0;
        py[i]  <= '0;
      end
    end else begin
      presc          <= tick ? '0 : presc + 18'd1;
      c_d            <= C;
      explosion_SCEN <= grant;
      if (grant) begin
        e_x <= grant_x;
        e_y <= grant_y;
      end
      bombs_free <= free_n;
      for (int unsigned i = 0; i < MAX_BOMBS; i++) begin
        st[i]          <= st_n[i];
        cnt[i]         <= cnt_n[i];
        px[i]          <= px_n[i];
        py[i]          <= py_n[i];
        bomb_valid[i]  <= (st_n[i] == S_ARMED) || (st_n[i] == S_PENDING);
        blast_valid[i] <= (st_n[i] == S_BLAST);
      end
    end
  end

  for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_pos
    assign bomb_x[10*g +: 10] = px[g];
    assign bomb_y[10*g +: 10] = py[g];
  end

endmodule
